// File: rtl/meduram_pkg.sv
// Shared helpers for the BRAM read switch: select-field geometry, latency bounds
// and the entry carried down each agent's return pipeline.
package meduram_pkg;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;
  localparam int MAX_BANK_W     = 8;

  function automatic int bank_w(input int nb);
    return (nb <= 1) ? 1 : $clog2(nb);
  endfunction

  function automatic int select_w(input int nb_bank, input int wr_col);
    return bank_w(nb_bank) + wr_col;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [MAX_BANK_W-1:0] bank;
    logic                  wcol;
    logic                  rcol;
  } ret_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating
// pointer; the pointer moves past the winner whenever advance_i is high.
module rr_arbiter
  import meduram_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = bank_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] winner_o
);

  logic [IW-1:0] ptr_q, ptr_d, win_q, win_d;
  logic          found;

  always_comb begin
    int            tmp;
    logic [IW-1:0] idx;
    found = 1'b0;
    win_d = win_q;
    tmp   = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      tmp = int'(ptr_q) + k;
      if (tmp >= N) tmp = tmp - N;
      idx = IW'(tmp);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win_d = idx;
      end
    end
    grant_o = '0;
    if (found) grant_o[win_d] = 1'b1;
    winner_o = win_d;
    ptr_d    = ptr_q;
    if (advance_i && found)
      ptr_d = (int'(win_d) == N - 1) ? '0 : win_d + IW'(1);
  end

  // win_q keeps the last winner so the bank address is stable while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      win_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/read_crossbar.sv
// Read switch between NB_RDAGENT agents and NB_BANK BRAM banks: per-bank
// round-robin arbitration with stall, and a per-agent return pipeline.
module read_crossbar
  import meduram_pkg::*;
#(
  parameter  int ADDR_WIDTH      = 8,
  parameter  int DATA_WIDTH      = 32,
  parameter  int NB_BANK         = 2,
  parameter  int NB_RDAGENT      = 4,
  parameter  int RD_LATENCY      = 1,
  parameter  int WRITE_COLLISION = 1,
  localparam int BANK_W          = bank_w(NB_BANK),
  localparam int SELECT_WIDTH    = select_w(NB_BANK, WRITE_COLLISION)
) (
  input  logic                               aclk,
  input  logic                               srst,
  input  logic [NB_RDAGENT-1:0]              m_rden,
  output logic [NB_RDAGENT-1:0]              m_rdready,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr,
  input  logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select,
  output logic [NB_RDAGENT-1:0]              m_rdvalid,
  output logic [NB_RDAGENT*DATA_WIDTH-1:0]   m_rddata,
  output logic [NB_RDAGENT*2-1:0]            m_rdcollision,
  output logic [NB_BANK-1:0]                 s_rden,
  output logic [NB_BANK*ADDR_WIDTH-1:0]      s_rdaddr,
  input  logic [NB_BANK*DATA_WIDTH-1:0]      s_rddata
);

  localparam int AGENT_W = bank_w(NB_RDAGENT);
  localparam int LAT = (RD_LATENCY < RD_LATENCY_MIN) ? RD_LATENCY_MIN :
                       (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;

  logic [NB_RDAGENT-1:0][SELECT_WIDTH-1:0] sel;
  logic [NB_RDAGENT-1:0][ADDR_WIDTH-1:0]   addr;
  logic [NB_BANK-1:0][DATA_WIDTH-1:0]      bdata;
  logic [NB_BANK-1:0][ADDR_WIDTH-1:0]      baddr;
  logic [NB_RDAGENT-1:0][BANK_W-1:0]       abank;
  logic [NB_RDAGENT-1:0]                   awcol, arcol;
  logic [NB_BANK-1:0][NB_RDAGENT-1:0]      req, grant;
  logic [NB_BANK-1:0][AGENT_W-1:0]         winner;
  logic [NB_BANK-1:0]                      multi;

  assign sel      = bank_select;
  assign addr     = m_rdaddr;
  assign bdata    = s_rddata;
  assign s_rdaddr = baddr;

  for (genvar a = 0; a < NB_RDAGENT; a++) begin : g_sel
    assign abank[a] = sel[a][BANK_W-1:0];
    if (WRITE_COLLISION != 0) begin : g_wc
      assign awcol[a] = sel[a][SELECT_WIDTH-1];
    end else begin : g_nwc
      assign awcol[a] = 1'b0;
    end
  end

  // Out-of-range bank indices simply never match, so such agents stay stalled
  for (genvar b = 0; b < NB_BANK; b++) begin : g_bank
    for (genvar a = 0; a < NB_RDAGENT; a++) begin : g_req
      assign req[b][a] = m_rden[a] && (abank[a] == BANK_W'(b));
    end
    assign multi[b]  = |(req[b] & (req[b] - NB_RDAGENT'(1)));
    assign s_rden[b] = |req[b];
    assign baddr[b]  = addr[winner[b]];

    rr_arbiter #(.N(NB_RDAGENT)) u_arb (
      .clk       (aclk),
      .rst       (srst),
      .req_i     (req[b]),
      .advance_i (|req[b]),
      .grant_o   (grant[b]),
      .winner_o  (winner[b])
    );
  end

  always_comb begin
    m_rdready = '0;
    arcol     = '0;
    for (int b = 0; b < NB_BANK; b++)
      for (int a = 0; a < NB_RDAGENT; a++)
        if (grant[b][a]) begin
          m_rdready[a] = 1'b1;
          arcol[a]     = multi[b];
        end
  end

  // Entry exits after LAT cycles, aligned with the bank's data for that read
  for (genvar a = 0; a < NB_RDAGENT; a++) begin : g_ret
    ret_entry_t            pipe_q [LAT];
    ret_entry_t            head;
    logic [DATA_WIDTH-1:0] data_q, rdata;

    assign head = pipe_q[LAT-1];

    always_ff @(posedge aclk) begin
      if (srst) begin
        for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
        data_q <= '0;
      end else begin
        pipe_q[0] <= '{valid: m_rdready[a], bank: MAX_BANK_W'(abank[a]),
                       wcol: awcol[a], rcol: arcol[a]};
        for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
        if (head.valid) data_q <= rdata;
      end
    end

    always_comb begin
      rdata = data_q;
      for (int b = 0; b < NB_BANK; b++)
        if (head.bank == MAX_BANK_W'(b)) rdata = bdata[b];
    end

    assign m_rdvalid[a]                             = head.valid;
    assign m_rddata[a*DATA_WIDTH +: DATA_WIDTH]     = head.valid ? rdata : data_q;
    assign m_rdcollision[a*2 +: 2]                  = head.valid ? {head.rcol, head.wcol} : 2'b00;
  end

endmodule

// File: tb/tb_read_crossbar.sv
// Directed bench for read_crossbar: two instances (latency 2 and 3) share the
// agent inputs; each has its own behavioural bank model.
module tb_read_crossbar;

  localparam int NA = 4;
  localparam int NB = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = 2;

  logic                  aclk = 1'b0;
  logic                  srst;
  logic [NA-1:0]         m_rden;
  logic [NA-1:0][AW-1:0] m_rdaddr;
  logic [NA-1:0][SW-1:0] bank_select;

  logic [NA-1:0]         rdy2, vld2, rdy3, vld3;
  logic [NA-1:0][DW-1:0] dat2, dat3;
  logic [NA-1:0][1:0]    col2, col3;
  logic [NB-1:0]         ren2, ren3;
  logic [NB-1:0][AW-1:0] sa2, sa3;
  logic [NB-1:0][DW-1:0] sd2, sd3;
  logic [NB-1:0][AW-1:0] bp2 [2];
  logic [NB-1:0][AW-1:0] bp3 [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  read_crossbar #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_BANK(NB), .NB_RDAGENT(NA),
                  .RD_LATENCY(2), .WRITE_COLLISION(1)) dut (
    .aclk(aclk), .srst(srst), .m_rden(m_rden), .m_rdready(rdy2), .m_rdaddr(m_rdaddr),
    .bank_select(bank_select), .m_rdvalid(vld2), .m_rddata(dat2), .m_rdcollision(col2),
    .s_rden(ren2), .s_rdaddr(sa2), .s_rddata(sd2));

  read_crossbar #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_BANK(NB), .NB_RDAGENT(NA),
                  .RD_LATENCY(3), .WRITE_COLLISION(1)) dut3 (
    .aclk(aclk), .srst(srst), .m_rden(m_rden), .m_rdready(rdy3), .m_rdaddr(m_rdaddr),
    .bank_select(bank_select), .m_rdvalid(vld3), .m_rddata(dat3), .m_rdcollision(col3),
    .s_rden(ren3), .s_rdaddr(sa3), .s_rddata(sd3));

  function automatic logic [31:0] bd(input int b, input logic [7:0] a);
    return 32'hD000_0000 | (32'(b) << 16) | {24'h0, a};
  endfunction

  // Bank model: data for an address appears exactly RD_LATENCY cycles later
  always @(posedge aclk) begin
    bp2[0] <= sa2;
    bp2[1] <= bp2[0];
    bp3[0] <= sa3;
    bp3[1] <= bp3[0];
    bp3[2] <= bp3[1];
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    assign sd2[b] = bd(b, bp2[1][b]);
    assign sd3[b] = bd(b, bp3[2][b]);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic req(input logic [1:0] a, input logic bank, input logic wc, input logic [7:0] ad);
    m_rden[a]      = 1'b1;
    bank_select[a] = {wc, bank};
    m_rdaddr[a]    = ad;
  endtask

  initial begin
    int          gseq [6];
    logic [1:0]  g;
    gseq = '{0, 2, 3, 0, 2, 3};
    srst = 1'b1;
    m_rden = '0;
    m_rdaddr = '0;
    bank_select = '0;

    // reset and quiet
    repeat (3) cyc();
    #2;
    check("rst_vld",  64'(vld2), 64'(0));
    check("rst_col",  64'(col2), 64'(0));
    check("rst_dat",  64'(dat2[0]) | 64'(dat2[3]), 64'(0));
    check("rst_ren",  64'(ren2), 64'(0));
    check("rst_rdy",  64'(rdy2), 64'(0));
    check("rst_vld3", 64'(vld3), 64'(0));
    srst = 1'b0;
    cyc(); cyc(); #2;
    check("idle_vld", 64'(vld2), 64'(0));
    check("idle_ren", 64'(ren2), 64'(0));

    // single read, agent 1 -> bank 1
    cyc(); req(2'd1, 1'b1, 1'b0, 8'h5A); #2;
    check("sgl_ren",  64'(ren2), 64'(2'b10));
    check("sgl_addr", 64'(sa2[1]), 64'(8'h5A));
    check("sgl_rdy",  64'(rdy2), 64'(4'b0010));
    cyc(); m_rden = '0; #2;
    check("sgl_vld_t1", 64'(vld2), 64'(0));
    cyc(); #2;
    check("sgl_vld_t2", 64'(vld2), 64'(4'b0010));
    check("sgl_dat",    64'(dat2[1]), 64'(bd(1, 8'h5A)));
    check("sgl_col",    64'(col2[1]), 64'(2'b00));
    cyc(); #2;
    check("sgl_vld_t3", 64'(vld2), 64'(0));
    check("sgl_hold",   64'(dat2[1]), 64'(bd(1, 8'h5A)));

    // contention: agents 0,2,3 on bank 0
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i < 6) begin
        req(2'd0, 1'b0, 1'b0, 8'h10);
        req(2'd2, 1'b0, 1'b0, 8'h12);
        req(2'd3, 1'b0, 1'b0, 8'h13);
      end else m_rden = '0;
      #2;
      if (i < 6) begin
        g = 2'(gseq[i]);
        check("rr_rdy",  64'(rdy2), 64'(4'b0001 << g));
        check("rr_addr", 64'(sa2[0]), 64'(8'h10 + 8'(g)));
      end
      if (i >= 2) begin
        g = 2'(gseq[i-2]);
        check("rr_vld", 64'(vld2), 64'(4'b0001 << g));
        check("rr_dat", 64'(dat2[g]), 64'(bd(0, 8'h10 + 8'(g))));
        check("rr_col", 64'(col2[g]), 64'(2'b10));
      end
    end

    // parallel banks
    cyc(); m_rden = '0;
    req(2'd0, 1'b0, 1'b0, 8'h21);
    req(2'd1, 1'b1, 1'b0, 8'h22);
    #2;
    check("par_rdy", 64'(rdy2), 64'(4'b0011));
    check("par_ren", 64'(ren2), 64'(2'b11));
    cyc(); m_rden = '0; #2;
    cyc(); #2;
    check("par_vld",  64'(vld2), 64'(4'b0011));
    check("par_col",  64'(col2), 64'(0));
    check("par_dat0", 64'(dat2[0]), 64'(bd(0, 8'h21)));
    check("par_dat1", 64'(dat2[1]), 64'(bd(1, 8'h22)));

    // write-collision pass-through on one beat only
    cyc(); req(2'd2, 1'b1, 1'b1, 8'h33); #2;
    check("wc_rdy0", 64'(rdy2), 64'(4'b0100));
    cyc(); req(2'd2, 1'b1, 1'b0, 8'h34); #2;
    check("wc_rdy1", 64'(rdy2), 64'(4'b0100));
    cyc(); m_rden = '0; #2;
    check("wc_vld0", 64'(vld2), 64'(4'b0100));
    check("wc_col0", 64'(col2[2]), 64'(2'b01));
    check("wc_dat0", 64'(dat2[2]), 64'(bd(1, 8'h33)));
    cyc(); #2;
    check("wc_vld1", 64'(vld2), 64'(4'b0100));
    check("wc_col1", 64'(col2[2]), 64'(2'b00));
    check("wc_dat1", 64'(dat2[2]), 64'(bd(1, 8'h34)));
    cyc(); #2;
    check("wc_done", 64'(vld2), 64'(0));

    // reset mid-flight: bank-0 pointer is 1 here, reset must bring it to 0
    cyc(); req(2'd3, 1'b1, 1'b0, 8'h44); #2;
    check("mid_rdy", 64'(rdy3), 64'(4'b1000));
    cyc(); m_rden = '0; srst = 1'b1; #2;
    cyc(); srst = 1'b0; #2;
    check("mid_vld_t2", 64'(vld3), 64'(0));
    check("mid_vld2",   64'(vld2), 64'(0));
    cyc(); #2;
    check("mid_vld_t3", 64'(vld3), 64'(0));
    check("mid_dat",    64'(dat3[3]), 64'(0));
    cyc(); req(2'd0, 1'b0, 1'b0, 8'h50); req(2'd1, 1'b0, 1'b0, 8'h51); #2;
    check("mid_ptr3", 64'(rdy3), 64'(4'b0001));
    check("mid_ptr2", 64'(rdy2), 64'(4'b0001));
    cyc(); m_rden = '0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
